// File: rtl/crc_arbiter_pkg.sv
// Shared definitions for the two-requester CRC arbiter: FSM encoding,
// default widths and the requester count.
package crc_arbiter_pkg;

  localparam int NUM_REQ     = 2;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_CRC_W   = 17;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/crc_arbiter_if.sv
// Bundles the requester handshake and the CRC engine connection of the arbiter.
// The slave side is the arbiter; the master side is requesters plus engine.
interface crc_arbiter_if
  import crc_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CRC_W  = DEF_CRC_W
);

  logic [NUM_REQ-1:0] req;
  logic [DATA_W-1:0]  data0;
  logic [DATA_W-1:0]  data1;
  logic [NUM_REQ-1:0] ack;
  logic [CRC_W-1:0]   result;
  logic               err;
  logic               busy;
  logic               crc_start;
  logic [DATA_W-1:0]  crc_data_in;
  logic               crc_rst;
  logic [CRC_W-1:0]   crc_data_out;
  logic               crc_done;

  modport slave (
    input  req, data0, data1, crc_data_out, crc_done,
    output ack, result, err, busy, crc_start, crc_data_in, crc_rst
  );

  modport master (
    output req, data0, data1, crc_data_out, crc_done,
    input  ack, result, err, busy, crc_start, crc_data_in, crc_rst
  );

endinterface

// File: rtl/crc_arbiter_rr_pick2.sv
// Two-way round-robin pick: the requester named by pointer wins if it is
// asking, otherwise the other one does.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       pointer,
  output logic       valid,
  output logic       winner
);

  assign valid  = |req;
  assign winner = req[pointer] ? pointer : ~pointer;

endmodule

// File: rtl/crc_arbiter.sv
// Arbitrates two requesters onto one CRC engine: grant, start the engine,
// wait for done (bounded by TIMEOUT), then acknowledge the winner.
module crc_arbiter
  import crc_arbiter_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CRC_W   = DEF_CRC_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  crc_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t             state;
  state_t             state_next;
  logic               grant;
  logic               pointer;
  logic [CNT_W-1:0]   count;
  logic               reset_hold;
  logic               pick_valid;
  logic               pick_winner;
  logic               timeout_hit;

  rr_pick2 u_pick (
    .req     (bus.req),
    .pointer (pointer),
    .valid   (pick_valid),
    .winner  (pick_winner)
  );

  assign timeout_hit = (count == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (pick_valid) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (bus.crc_done || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers; crc_done is only looked at in WAIT so stray pulses vanish.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant           <= 1'b0;
      pointer         <= 1'b0;
      count           <= '0;
      reset_hold      <= 1'b1;
      bus.result      <= {CRC_W{1'b0}};
      bus.err         <= 1'b0;
      bus.crc_data_in <= {DATA_W{1'b0}};
    end else begin
      reset_hold <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            grant           <= pick_winner;
            bus.crc_data_in <= pick_winner ? bus.data1 : bus.data0;
          end
        end
        ISSUE: count <= '0;
        WAIT: begin
          count <= count + CNT_W'(1);
          if (bus.crc_done) begin
            bus.result <= bus.crc_data_out;
            bus.err    <= 1'b0;
          end else if (timeout_hit) begin
            bus.result <= {CRC_W{1'b0}};
            bus.err    <= 1'b1;
          end
        end
        RESP: pointer <= ~grant;
        default: ;
      endcase
    end
  end

  // reset_hold keeps the engine in reset until the first clock after rst rises.
  assign bus.busy      = (state != IDLE);
  assign bus.crc_start = (state == ISSUE);
  assign bus.ack       = (state == RESP) ? (2'b01 << grant) : 2'b00;
  assign bus.crc_rst   = reset_hold | ((state == RESP) & bus.err);

endmodule

// File: tb/tb_crc_arbiter.sv
// Self-checking bench for crc_arbiter: a vector table, hand-written corner
// sequences and random transactions against a rule-level reference model.
module tb_crc_arbiter;

  localparam int DATA_W      = 32;
  localparam int CRC_W       = 17;
  localparam int TIMEOUT     = 255;
  localparam int WATCH_LIMIT = 400;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  crc_arbiter_if #(.DATA_W(DATA_W), .CRC_W(CRC_W)) bus ();

  crc_arbiter #(.DATA_W(DATA_W), .CRC_W(CRC_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Mock engine: done pulses eng_delay clocks after it sees start; 0 means never.
  int               eng_delay  = 0;
  int               eng_cnt    = 0;
  logic             eng_done   = 1'b0;
  logic             stray_done = 1'b0;
  logic [CRC_W-1:0] eng_value  = '0;

  assign bus.crc_done     = eng_done | stray_done;
  assign bus.crc_data_out = eng_value;

  always @(posedge clk) begin
    eng_done <= 1'b0;
    if (bus.crc_start) begin
      eng_cnt <= eng_delay;
    end else if (eng_cnt > 1) begin
      eng_cnt <= eng_cnt - 1;
    end else if (eng_cnt == 1) begin
      eng_cnt  <= 0;
      eng_done <= 1'b1;
    end
  end

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int pass_cnt  = 0;
  int check_cnt = 0;

  typedef struct {
    logic [1:0]        req;
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
    int                delay;
    logic [CRC_W-1:0]  value;
    logic [1:0]        exp_ack;
    logic [DATA_W-1:0] exp_data;
    logic [CRC_W-1:0]  exp_result;
    logic              exp_err;
    int                exp_delta;
  } vec_t;

  vec_t vecs[7];

  logic              obs_ok;
  logic [1:0]        obs_ack;
  logic [CRC_W-1:0]  obs_result;
  logic              obs_err;
  logic              obs_crc_rst;
  logic [DATA_W-1:0] obs_data;
  int                obs_starts;
  int                obs_delta;
  int                last_served;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  task automatic apply_stimulus(input logic [1:0] req, input logic [DATA_W-1:0] d0,
                                input logic [DATA_W-1:0] d1, input int delay,
                                input logic [CRC_W-1:0] value);
    @(negedge clk);
    bus.data0 = d0;
    bus.data1 = d1;
    eng_delay = delay;
    eng_value = value;
    bus.req   = req;
  endtask

  // Follows one transaction from start pulse to ack, sampling on falling edges.
  task automatic watch_txn(input bit drop_req);
    int issue_cyc;
    issue_cyc   = 0;
    obs_ok      = 1'b0;
    obs_starts  = 0;
    obs_ack     = '0;
    obs_result  = '0;
    obs_err     = 1'b0;
    obs_crc_rst = 1'b0;
    obs_data    = '0;
    obs_delta   = -1;
    for (int k = 0; k < WATCH_LIMIT; k++) begin
      @(negedge clk);
      if (bus.crc_start) begin
        obs_starts++;
        issue_cyc = cycle;
        obs_data  = bus.crc_data_in;
      end
      if (bus.ack != 2'b00) begin
        obs_ack     = bus.ack;
        obs_result  = bus.result;
        obs_err     = bus.err;
        obs_crc_rst = bus.crc_rst;
        obs_delta   = cycle - issue_cyc;
        obs_ok      = 1'b1;
        if (drop_req) bus.req = 2'b00;
        break;
      end
    end
    check_output("ack_within_limit", obs_ok, 1);
  endtask

  task automatic run_txn(input string tag, input logic [1:0] req,
                         input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                         input int delay, input logic [CRC_W-1:0] value,
                         input logic [1:0] exp_ack, input logic [DATA_W-1:0] exp_data,
                         input logic [CRC_W-1:0] exp_result, input logic exp_err,
                         input int exp_delta);
    apply_stimulus(req, d0, d1, delay, value);
    watch_txn(1'b1);
    check_output({tag, "_ack"}, obs_ack, exp_ack);
    check_output({tag, "_data_in"}, obs_data, exp_data);
    check_output({tag, "_result"}, obs_result, exp_result);
    check_output({tag, "_err"}, obs_err, exp_err);
    check_output({tag, "_crc_rst"}, obs_crc_rst, exp_err);
    check_output({tag, "_latency"}, obs_delta, exp_delta);
    check_output({tag, "_starts"}, obs_starts, 1);
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < WATCH_LIMIT; k++) begin
      @(negedge clk);
      if (bus.crc_start) begin
        seen = 1'b1;
        break;
      end
    end
    check_output("start_within_limit", seen, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_ack"}, bus.ack, 0);
    check_output({tag, "_crc_start"}, bus.crc_start, 0);
    check_output({tag, "_busy"}, bus.busy, 0);
    check_output({tag, "_err"}, bus.err, 0);
    check_output({tag, "_result"}, bus.result, 0);
    check_output({tag, "_crc_data_in"}, bus.crc_data_in, 0);
    check_output({tag, "_crc_rst"}, bus.crc_rst, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  // Reference rule: a lone request wins; with both, whoever was not served last.
  function automatic int predict_winner(input logic [1:0] req, input int last);
    if (req == 2'b01) return 0;
    if (req == 2'b10) return 1;
    return (last == 0) ? 1 : 0;
  endfunction

  initial begin
    bit seen;
    bus.req   = 2'b00;
    bus.data0 = '0;
    bus.data1 = '0;

    vecs[0] = '{2'b01, 32'hDEADBEEF, 32'h00000000,  10, 17'h1ABCD, 2'b01, 32'hDEADBEEF, 17'h1ABCD, 1'b0,  12};
    vecs[1] = '{2'b10, 32'h11111111, 32'h12345678,   1, 17'h00001, 2'b10, 32'h12345678, 17'h00001, 1'b0,   3};
    vecs[2] = '{2'b11, 32'hA5A5A5A5, 32'h5A5A5A5A,   3, 17'h0F0F0, 2'b01, 32'hA5A5A5A5, 17'h0F0F0, 1'b0,   5};
    vecs[3] = '{2'b11, 32'h01020304, 32'h0A0B0C0D, 254, 17'h1FFFF, 2'b10, 32'h0A0B0C0D, 17'h1FFFF, 1'b0, 256};
    vecs[4] = '{2'b01, 32'hFFFFFFFF, 32'h00000000,   0, 17'h12345, 2'b01, 32'hFFFFFFFF, 17'h00000, 1'b1, 256};
    vecs[5] = '{2'b11, 32'h13579BDF, 32'h2468ACE0, 255, 17'h0BEEF, 2'b10, 32'h2468ACE0, 17'h00000, 1'b1, 256};
    vecs[6] = '{2'b10, 32'h00000000, 32'h87654321,   2, 17'h0A5A5, 2'b10, 32'h87654321, 17'h0A5A5, 1'b0,   4};

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);
    check_output("crc_rst_release", bus.crc_rst, 0);

    for (int i = 0; i < 7; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].req, vecs[i].d0, vecs[i].d1, vecs[i].delay,
              vecs[i].value, vecs[i].exp_ack, vecs[i].exp_data, vecs[i].exp_result,
              vecs[i].exp_err, vecs[i].exp_delta);
    end

    // Both requests held from reset: strict alternation, and never a grant on the ack cycle.
    @(negedge clk);
    rst       = 1'b0;
    bus.req   = 2'b11;
    bus.data0 = 32'h0000AAAA;
    bus.data1 = 32'h0000BBBB;
    eng_delay = 3;
    eng_value = 17'h00123;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      watch_txn(1'b0);
      check_output($sformatf("rr%0d_ack", i), obs_ack, (i % 2 == 0) ? 2'b01 : 2'b10);
      check_output($sformatf("rr%0d_data_in", i), obs_data,
                   (i % 2 == 0) ? 32'h0000AAAA : 32'h0000BBBB);
      @(negedge clk);
      check_output($sformatf("rr%0d_idle_after_ack", i), bus.busy, 0);
    end
    bus.req = 2'b00;

    // Requester drops its level and changes its data mid-WAIT.
    apply_stimulus(2'b01, 32'hCAFEF00D, 32'h0, 20, 17'h15555);
    wait_start(seen);
    repeat (3) @(negedge clk);
    bus.req   = 2'b00;
    bus.data0 = 32'h0;
    @(negedge clk);
    check_output("drop_data_in_held", bus.crc_data_in, 32'hCAFEF00D);
    watch_txn(1'b1);
    check_output("drop_ack", obs_ack, 2'b01);
    check_output("drop_result", obs_result, 17'h15555);

    // Stray done while idle must not pre-complete the next transaction.
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    check_output("stray_idle_busy", bus.busy, 0);
    run_txn("stray", 2'b01, 32'h00C0FFEE, 32'h0, 6, 17'h00666,
            2'b01, 32'h00C0FFEE, 17'h00666, 1'b0, 8);

    // Reset mid-WAIT aborts with no ack; the next request is served normally.
    apply_stimulus(2'b01, 32'h77777777, 32'h0, 50, 17'h17777);
    wait_start(seen);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) begin
      @(negedge clk);
      check_output("abort_no_ack", bus.ack, 0);
    end
    rst     = 1'b1;
    bus.req = 2'b00;
    @(negedge clk);
    check_output("abort_crc_rst_release", bus.crc_rst, 0);
    run_txn("after_abort", 2'b10, 32'h0, 32'h31415926, 4, 17'h02718,
            2'b10, 32'h31415926, 17'h02718, 1'b0, 6);
    last_served = 1;

    // Random transactions against the rule-level model.
    for (int i = 0; i < 16; i++) begin
      logic [1:0]        r;
      logic [DATA_W-1:0] d0;
      logic [DATA_W-1:0] d1;
      logic [CRC_W-1:0]  v;
      int                dly;
      int                w;
      bit                done_in_time;
      r   = 2'($urandom_range(1, 3));
      d0  = $urandom;
      d1  = $urandom;
      v   = CRC_W'($urandom);
      dly = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 30));
      w   = predict_winner(r, last_served);
      last_served  = w;
      done_in_time = (dly != 0) && (dly + 1 <= TIMEOUT);
      run_txn($sformatf("rand%0d", i), r, d0, d1, dly, v,
              (w == 0) ? 2'b01 : 2'b10, (w == 0) ? d0 : d1,
              done_in_time ? v : '0, !done_in_time,
              done_in_time ? dly + 2 : TIMEOUT + 1);
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
